// File: rtl/dac_multi_channel_driver_if.sv
// Sample-input handshake, control and DAC pin bundle for the multi-channel
// DAC driver.
interface dac_multi_channel_driver_if #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 8
);
  logic [N_CH*DATA_W-1:0] IN_DATA;
  logic [N_CH-1:0]        IN_VALID;
  logic [N_CH-1:0]        IN_READY;
  logic [N_CH-1:0]        CH_EN;
  logic                   FMT_TWOS;
  logic                   CLR_STATUS;
  logic [N_CH-1:0]        DA_CLK;
  logic [N_CH-1:0]        DA_WRT;
  logic [N_CH*DATA_W-1:0] DA_DBP;
  logic [N_CH-1:0]        UNDERFLOW;

  modport master (
    output IN_DATA,
    output IN_VALID,
    output CH_EN,
    output FMT_TWOS,
    output CLR_STATUS,
    input  IN_READY,
    input  DA_CLK,
    input  DA_WRT,
    input  DA_DBP,
    input  UNDERFLOW
  );

  modport slave (
    input  IN_DATA,
    input  IN_VALID,
    input  CH_EN,
    input  FMT_TWOS,
    input  CLR_STATUS,
    output IN_READY,
    output DA_CLK,
    output DA_WRT,
    output DA_DBP,
    output UNDERFLOW
  );
endinterface

// File: rtl/dac_multi_channel_driver.sv
// N-channel parallel DAC driver: per-channel sample FIFO, shared sample-rate
// divider, format conversion and registered DAC clock/strobe/data pins.
module dac_multi_channel_driver #(
  parameter int N_CH        = 2,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int DIV         = 4,
  parameter bit SYNC_UPDATE = 1'b1
) (
  input  logic                     CLK_IN,
  input  logic                     RESET,
  dac_multi_channel_driver_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = $clog2(DIV);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
  localparam logic [NW-1:0] OCC_FULL = NW'(DEPTH);
  localparam logic [DATA_W-1:0] MID =
    {1'b1, {(DATA_W-1){1'b0}}};

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dclk_q, dclk_d;
  logic          tick;

  logic [N_CH-1:0][DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [N_CH-1:0][AW-1:0]     wptr_q, wptr_d;
  logic [N_CH-1:0][AW-1:0]     rptr_q, rptr_d;
  logic [N_CH-1:0][NW-1:0]     occ_q, occ_d;
  logic [N_CH-1:0][DATA_W-1:0] dbp_q, dbp_d;

  logic [N_CH-1:0] rdy_q, rdy_d;
  logic [N_CH-1:0] uf_q, uf_d;
  logic [N_CH-1:0] push, pop, empty;
  logic            all_ok;

  function automatic logic [DATA_W-1:0] conv(
    input logic              twos,
    input logic [DATA_W-1:0] d
  );
    return twos ? {~d[DATA_W-1], d[DATA_W-2:0]} : d;
  endfunction

  assign tick   = (cnt_q == CNT_LAST);
  assign cnt_d  = tick ? '0 : cnt_q + CW'(1);
  // Pin clock is a registered copy of the phase it will show next cycle
  assign dclk_d = (cnt_d >= CNT_HALF);

  always_comb begin
    all_ok = 1'b1;
    empty  = '0;
    for (int k = 0; k < N_CH; k++) begin
      empty[k] = (occ_q[k] == '0);
      if (bus.CH_EN[k] && empty[k]) all_ok = 1'b0;
    end
  end

  always_comb begin
    push   = '0;
    pop    = '0;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    rdy_d  = rdy_q;
    uf_d   = uf_q;
    dbp_d  = dbp_q;
    for (int k = 0; k < N_CH; k++) begin
      push[k] = bus.IN_VALID[k] & rdy_q[k];
      // In lock-step mode one starved channel stalls every enabled channel
      pop[k]  = tick & bus.CH_EN[k] & ~empty[k]
                & (all_ok | ~SYNC_UPDATE);
      wptr_d[k] = wptr_q[k] + AW'(push[k]);
      rptr_d[k] = rptr_q[k] + AW'(pop[k]);
      occ_d[k]  = occ_q[k] + NW'(push[k]) - NW'(pop[k]);
      rdy_d[k]  = (occ_d[k] != OCC_FULL);
      uf_d[k]   = (tick & bus.CH_EN[k] & empty[k])
                | (uf_q[k] & ~bus.CLR_STATUS);
      if (tick) begin
        if (!bus.CH_EN[k]) begin
          dbp_d[k] = MID;
        end else if (pop[k]) begin
          dbp_d[k] = conv(bus.FMT_TWOS, mem_q[k][rptr_q[k]]);
        end
      end
    end
  end

  always_ff @(posedge CLK_IN) begin
    for (int k = 0; k < N_CH; k++) begin
      if (push[k]) begin
        mem_q[k][wptr_q[k]] <= bus.IN_DATA[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET) begin
    if (!RESET) begin
      cnt_q  <= '0;
      dclk_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      rdy_q  <= '1;
      uf_q   <= '0;
      dbp_q  <= {N_CH{MID}};
    end else begin
      cnt_q  <= cnt_d;
      dclk_q <= dclk_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      rdy_q  <= rdy_d;
      uf_q   <= uf_d;
      dbp_q  <= dbp_d;
    end
  end

  assign bus.IN_READY  = rdy_q;
  assign bus.UNDERFLOW = uf_q;
  assign bus.DA_CLK    = {N_CH{dclk_q}};
  assign bus.DA_WRT    = {N_CH{dclk_q}};
  assign bus.DA_DBP    = dbp_q;

endmodule

// File: tb/tb_dac_multi_channel_driver.sv
// Directed bench for dac_multi_channel_driver: one independent-update and
// one lock-step instance driven from a shared clock and reset.
module tb_dac_multi_channel_driver;
  localparam int NC  = 2;
  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int DV  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_multi_channel_driver_if #(.N_CH(NC), .DATA_W(DW)) i0 ();
  dac_multi_channel_driver_if #(.N_CH(NC), .DATA_W(DW)) i1 ();

  dac_multi_channel_driver #(
    .N_CH(NC), .DATA_W(DW), .DEPTH(DEP), .DIV(DV), .SYNC_UPDATE(1'b0)
  ) u0 (
    .CLK_IN(clk),
    .RESET (rst_n),
    .bus   (i0)
  );

  dac_multi_channel_driver #(
    .N_CH(NC), .DATA_W(DW), .DEPTH(DEP), .DIV(DV), .SYNC_UPDATE(1'b1)
  ) u1 (
    .CLK_IN(clk),
    .RESET (rst_n),
    .bus   (i1)
  );

  typedef struct {
    logic       fmt;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] e0;
    logic [7:0] e1;
  } fvec_t;

  fvec_t tbl [5];
  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    ncyc++;
  endtask

  task automatic to_tick();
    do step(); while (ncyc % DV != 0);
  endtask

  task automatic push0(input logic [1:0] v, input logic [15:0] d);
    i0.IN_VALID = v;
    i0.IN_DATA  = d;
    step();
    i0.IN_VALID = '0;
  endtask

  task automatic push1(input logic [1:0] v, input logic [15:0] d);
    i1.IN_VALID = v;
    i1.IN_DATA  = d;
    step();
    i1.IN_VALID = '0;
  endtask

  task automatic chk_pins(input string nm, input logic e);
    chk({nm, ".clk"}, {30'd0, i0.DA_CLK}, {30'd0, e, e});
    chk({nm, ".wrt"}, {30'd0, i0.DA_WRT}, {30'd0, e, e});
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".dbp0"}, {16'd0, i0.DA_DBP}, 32'h8080);
    chk({nm, ".dbp1"}, {16'd0, i1.DA_DBP}, 32'h8080);
    chk_pins(nm, 1'b0);
    chk({nm, ".uf0"}, {30'd0, i0.UNDERFLOW}, 32'd0);
    chk({nm, ".uf1"}, {30'd0, i1.UNDERFLOW}, 32'd0);
    chk({nm, ".rdy0"}, {30'd0, i0.IN_READY}, 32'd3);
    chk({nm, ".rdy1"}, {30'd0, i1.IN_READY}, 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 8'h00, 8'h7F, 8'h80, 8'hFF};
    tbl[1] = '{1'b1, 8'h80, 8'hFF, 8'h00, 8'h7F};
    tbl[2] = '{1'b0, 8'h5A, 8'hA5, 8'h5A, 8'hA5};
    tbl[3] = '{1'b1, 8'h01, 8'hFE, 8'h81, 8'h7E};
    tbl[4] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};

    i0.IN_DATA = '0; i0.IN_VALID = '0; i0.CH_EN = '0;
    i0.FMT_TWOS = 1'b0; i0.CLR_STATUS = 1'b0;
    i1.IN_DATA = '0; i1.IN_VALID = '0; i1.CH_EN = '0;
    i1.FMT_TWOS = 1'b0; i1.CLR_STATUS = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    ncyc  = 0;
    for (int i = 0; i < 5; i++) begin
      chk_pins($sformatf("phase%0d", i), (i % DV) >= DV / 2);
      if (i < 4) step();
    end

    // independent streaming
    push0(2'b11, 16'h1110);
    push0(2'b11, 16'h2120);
    push0(2'b11, 16'h3130);
    i0.CH_EN = 2'b11;
    to_tick();
    chk("s.w0", {16'd0, i0.DA_DBP}, 32'h1110);
    repeat (3) step();
    chk("s.hold", {16'd0, i0.DA_DBP}, 32'h1110);
    chk_pins("s.hi", 1'b1);
    to_tick();
    chk("s.w1", {16'd0, i0.DA_DBP}, 32'h2120);
    to_tick();
    chk("s.w2", {16'd0, i0.DA_DBP}, 32'h3130);
    chk("s.uf0", {30'd0, i0.UNDERFLOW}, 32'd0);
    to_tick();
    chk("s.under", {16'd0, i0.DA_DBP}, 32'h3130);
    chk("s.uf", {30'd0, i0.UNDERFLOW}, 32'd3);

    i0.CH_EN = 2'b00;
    i0.CLR_STATUS = 1'b1;
    step();
    i0.CLR_STATUS = 1'b0;
    chk("clr.uf", {30'd0, i0.UNDERFLOW}, 32'd0);
    to_tick();
    chk("dis.mid", {16'd0, i0.DA_DBP}, 32'h8080);

    // fill ch0 past capacity while disabled
    for (int i = 0; i < 17; i++) begin
      i0.IN_VALID = 2'b01;
      i0.IN_DATA  = {8'h00, 8'(i)};
      step();
      if (i == 15) chk("full.rdy", {30'd0, i0.IN_READY}, 32'd2);
    end
    i0.IN_VALID = '0;
    chk("full.rdy2", {30'd0, i0.IN_READY}, 32'd2);
    i0.CH_EN = 2'b01;
    for (int i = 0; i < 16; i++) begin
      to_tick();
      chk($sformatf("full.out%0d", i), {16'd0, i0.DA_DBP},
          {16'd0, 8'h80, 8'(i)});
      if (i == 0) chk("full.rdy3", {30'd0, i0.IN_READY}, 32'd3);
    end
    to_tick();
    chk("full.drop", {16'd0, i0.DA_DBP}, 32'h800F);
    chk("full.uf", {30'd0, i0.UNDERFLOW}, 32'd1);
    i0.CH_EN = 2'b00;
    i0.CLR_STATUS = 1'b1;
    step();
    i0.CLR_STATUS = 1'b0;
    chk("full.clr", {30'd0, i0.UNDERFLOW}, 32'd0);

    // format table
    for (int v = 0; v < 5; v++) begin
      i0.FMT_TWOS = tbl[v].fmt;
      push0(2'b11, {tbl[v].d1, tbl[v].d0});
      i0.CH_EN = 2'b11;
      to_tick();
      chk($sformatf("fmt%0d", v), {16'd0, i0.DA_DBP},
          {16'd0, tbl[v].e1, tbl[v].e0});
      i0.CH_EN = 2'b00;
    end
    i0.FMT_TWOS = 1'b0;
    chk("fmt.uf", {30'd0, i0.UNDERFLOW}, 32'd0);
    to_tick();
    chk("fmt.mid", {16'd0, i0.DA_DBP}, 32'h8080);

    // lock-step instance: one starved channel stalls both
    push1(2'b01, 16'h00A1);
    push1(2'b01, 16'h00A2);
    push1(2'b01, 16'h00A3);
    i1.CH_EN = 2'b11;
    to_tick();
    chk("sync.hold", {16'd0, i1.DA_DBP}, 32'h8080);
    chk("sync.uf", {30'd0, i1.UNDERFLOW}, 32'd2);
    push1(2'b10, 16'h5500);
    to_tick();
    chk("sync.adv", {16'd0, i1.DA_DBP}, 32'h55A1);
    chk("sync.uf2", {30'd0, i1.UNDERFLOW}, 32'd2);
    to_tick();
    chk("sync.hold2", {16'd0, i1.DA_DBP}, 32'h55A1);

    // clear coincident with a new underflow: set wins
    i1.CLR_STATUS = 1'b1;
    repeat (3) step();
    chk("co.pre", {30'd0, i1.UNDERFLOW}, 32'd0);
    step();
    chk("co.set", {30'd0, i1.UNDERFLOW}, 32'd2);
    step();
    chk("co.clr", {30'd0, i1.UNDERFLOW}, 32'd0);
    i1.CLR_STATUS = 1'b0;
    i1.CH_EN = 2'b00;

    // asynchronous reset in the middle of a stream
    push0(2'b01, 16'h00C1);
    push0(2'b01, 16'h00C2);
    i0.CH_EN = 2'b11;
    to_tick();
    chk("ar.pre", {16'd0, i0.DA_DBP}, 32'h80C1);
    chk("ar.uf", {30'd0, i0.UNDERFLOW}, 32'd2);
    step();
    step();
    chk_pins("ar.hi", 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_reset("ar");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ncyc  = 0;
    repeat (3) step();
    chk_pins("ar.p3", 1'b1);
    chk("ar.uf3", {30'd0, i0.UNDERFLOW}, 32'd0);
    step();
    chk("ar.empty", {16'd0, i0.DA_DBP}, 32'h8080);
    chk("ar.uf4", {30'd0, i0.UNDERFLOW}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dac_multi_channel_driver.md
# dac_multi_channel_driver

Parametrised N-channel driver for AD9709-class parallel DACs, replacing per-channel clock domains with one system clock and an internal sample-rate divider. Each channel buffers incoming samples in a FIFO, converts format, and presents data, DAC clock and write strobe to the converter pins. Sits between the waveform/DDS generators and the DAC pins at the top of the signal-output path.

## Interface
- N_CH, 2, number of DAC channels
- DATA_W, 8, sample width per channel
- DEPTH, 16, FIFO entries per channel (power of 2, ≥2)
- DIV, 4, CLK_IN cycles per DAC sample (even, ≥2)
- SYNC_UPDATE, 1, 1 = all enabled channels advance together; 0 = independent
- CLK_IN  in  1  system clock; all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- IN_DATA  in  N_CH*DATA_W  sample per channel, channel k at [k*DATA_W +: DATA_W]
- IN_VALID  in  N_CH  per-channel push request
- IN_READY  out  N_CH  per-channel FIFO not full
- CH_EN  in  N_CH  channel enable
- FMT_TWOS  in  1  1 = input two's complement, 0 = straight binary
- CLR_STATUS  in  1  clears UNDERFLOW
- DA_CLK  out  N_CH  DAC clock per channel
- DA_WRT  out  N_CH  DAC write strobe per channel (identical to DA_CLK)
- DA_DBP  out  N_CH*DATA_W  DAC data bus per channel
- UNDERFLOW  out  N_CH  sticky per-channel underflow flag

## Operation
- Divider: cnt counts 0..DIV-1, wraps; tick = (cnt == DIV-1); shared by all channels.
- Push: IN_VALID[k] && IN_READY[k] writes IN_DATA slice into FIFO k at the edge. IN_READY[k] = !full[k]; push while full is dropped, FIFO unchanged.
- Pop at tick, per channel k:
  - CH_EN[k]=0: no pop, DA_DBP[k] loads midscale (1<<(DATA_W-1)); FIFO contents retained.
  - SYNC_UPDATE=0: enabled and non-empty → pop and load; enabled and empty → hold DA_DBP[k], set UNDERFLOW[k].
  - SYNC_UPDATE=1: if every enabled channel non-empty → all enabled pop and load; else no enabled channel pops, all hold, UNDERFLOW set for each enabled empty channel only.
- Format: loaded value = FMT_TWOS ? {~d[MSB], d[MSB-1:0]} : d; FMT_TWOS sampled at tick.
- No bypass: a word pushed in the tick cycle into an empty FIFO is not popped that tick (underflow is flagged).
- Occupancy counter width clog2(DEPTH)+1; read/write pointers wrap modulo DEPTH.
- UNDERFLOW: set wins over CLR_STATUS in the same cycle.
- CH_EN changes take effect only at tick.

## Timing
- Reset (RESET low, async): cnt=0, DA_CLK=0, DA_WRT=0, DA_DBP=midscale all channels, UNDERFLOW=0, FIFOs empty, IN_READY all 1 (pushes ignored while held in reset).
- All outputs registered, no combinational path from inputs to DA_* pins.
- DA_CLK/DA_WRT = 1 in cycles with cnt ∈ [DIV/2, DIV-1], 0 for cnt ∈ [0, DIV/2-1]; DIV=4 gives 0,0,1,1.
- DA_DBP changes only on the edge leaving cnt=DIV-1 (DA_CLK falling); DIV/2 cycles setup before the rising edge, DIV/2 hold after.
- Push-to-pin latency: word pushed at edge t appears on DA_DBP at the first tick edge ≥ t+1 when it is at FIFO head.
- IN_READY updates the cycle after the push/pop that changes fullness.
- Reset mid-operation: immediate return to reset values; first tick after release at 4th edge (cnt DIV-1) for DIV=4.

## Test plan
- Reset: N_CH=2, DATA_W=8 → DA_DBP=0x80/0x80, DA_CLK=00, UNDERFLOW=00, IN_READY=11; DA_CLK pattern 0,0,1,1 after release.
- Streaming, SYNC=0, DIV=4: push ch0 0x10,0x20,0x30, ch1 0x11,0x21,0x31, enable both → DA_DBP steps every 4 cycles in order on DA_CLK falling edges; then empty → holds 0x30/0x31, UNDERFLOW=11.
- Full: ch0 disabled, push 17 words 0x00..0x10 → IN_READY[0]=0 after 16th, 0x10 dropped; enable → 0x00..0x0F out in order.
- Sync: SYNC=1, ch0 holds 3 words, ch1 empty, both enabled → both hold, UNDERFLOW=01 is wrong, required 10; push ch1 0x55 → next tick both advance together.
- Format: FMT_TWOS=1, push 0x00,0x7F,0x80,0xFF → DA_DBP 0x80,0xFF,0x00,0x7F; disable channel → 0x80 at next tick.
- Async reset mid-stream and CLR_STATUS coincident with new underflow → immediate reset values; UNDERFLOW stays 1 in the coincident cycle, clears on a later CLR_STATUS.
